// File: rtl/ahb_burst_arbiter.sv
// Two-requester AHB master arbiter and NONSEQ/SEQ burst sequencer.
// Define AHB_ARB_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module ahb_burst_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                hreset,
    input  logic [1:0]          req,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [1:0]          req_write,
    input  logic [5:0]          req_burst,
    input  logic [5:0]          req_size,
    input  logic [2*DATA_W-1:0] req_wdata,
    input  logic                hready,
    input  logic                hresp,
    input  logic [DATA_W-1:0]   hrdata,
    output logic [1:0]          m_htrans,
    output logic [ADDR_W-1:0]   m_haddr,
    output logic                m_hwrite,
    output logic [2:0]          m_hburst,
    output logic [2:0]          m_hsize,
    output logic [DATA_W-1:0]   m_hwdata,
    output logic                m_enable,
    output logic [1:0]          grant,
    output logic [1:0]          beat_ack,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          done,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_ERR} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        burst_q, burst_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        beat_q, beat_d;
    logic              dphase_q, dphase_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              pick;
    logic [DATA_W-1:0] owner_wdata;

    function automatic logic [3:0] last_beat(input logic [2:0] burst);
        case (burst[2:1])
            2'b00:   last_beat = 4'd0;
            2'b01:   last_beat = 4'd3;
            2'b10:   last_beat = 4'd7;
            default: last_beat = 4'd15;
        endcase
    endfunction

    // WRAP bursts keep the upper bits fixed and wrap inside a beats*inc window.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        burst,
                                                    input logic [2:0]        size);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] sum;
        inc  = ADDR_W'(1) << size;
        mask = ((ADDR_W'(last_beat(burst)) + ADDR_W'(1)) << size) - ADDR_W'(1);
        sum  = addr + inc;
        if (!burst[0] && (burst[2:1] != 2'b00))
            next_addr = (addr & ~mask) | (sum & mask);
        else
            next_addr = sum;
    endfunction

`ifdef AHB_ARB_PRIO_EN
    always_comb pick = ~req[0];
`else
    logic last_q, last_d;

    always_comb pick = (&req) ? ~last_q : req[1];

    always_comb begin
        last_d = last_q;
        if (|done_d)
            last_d = owner_q;
    end

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    assign owner_wdata = owner_q ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        write_d    = write_q;
        burst_d    = burst_q;
        size_d     = size_q;
        beat_d     = beat_q;
        dphase_d   = dphase_q;
        grant_d    = grant_q;
        done_d     = 2'b00;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        hwdata_d   = hwdata_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d  = pick;
                    addr_d   = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    write_d  = pick ? req_write[1] : req_write[0];
                    burst_d  = pick ? req_burst[5:3] : req_burst[2:0];
                    size_d   = pick ? req_size[5:3] : req_size[2:0];
                    grant_d  = pick ? 2'b10 : 2'b01;
                    beat_d   = 4'd0;
                    dphase_d = 1'b0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (hready) begin
                    // The previous beat's data phase retires in the same cycle this address is accepted.
                    if (dphase_q && !write_q && !hresp) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = hrdata;
                    end
                    if (write_q)
                        hwdata_d = owner_wdata;
                    addr_d   = next_addr(addr_q, burst_q, size_q);
                    beat_d   = beat_q + 4'd1;
                    dphase_d = 1'b1;
                    if (beat_q == last_beat(burst_q))
                        state_d = S_DRAIN;
                end else if (hresp) begin
                    dphase_d = 1'b0;
                    state_d  = S_ERR;
                end
            end
            S_DRAIN: begin
                if (hready) begin
                    if (!write_q && !hresp) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = hrdata;
                    end
                    done_d   = grant_q;
                    grant_d  = 2'b00;
                    dphase_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (hresp) begin
                    dphase_d = 1'b0;
                    state_d  = S_ERR;
                end
            end
            S_ERR: begin
                if (hready) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            burst_q    <= 3'd0;
            size_q     <= 3'd0;
            beat_q     <= 4'd0;
            dphase_q   <= 1'b0;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
            dphase_q   <= dphase_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            hwdata_q   <= hwdata_d;
        end
    end

    assign m_htrans = (state_q == S_BURST) ? ((beat_q == 4'd0) ? HT_NONSEQ : HT_SEQ) : HT_IDLE;
    assign m_haddr  = addr_q;
    assign m_hwrite = write_q;
    assign m_hburst = burst_q;
    assign m_hsize  = size_q;
    assign m_hwdata = hwdata_q;
    assign m_enable = (state_q != S_IDLE);
    assign grant    = grant_q;
    assign beat_ack = ((state_q == S_BURST) && hready) ? grant_q : 2'b00;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/ahb_burst_arbiter.md
# ahb_burst_arbiter

Two-requester arbiter and burst sequencer sitting in front of the `top_ahb` master inputs. It grants the AHB master port to one requester at a time and converts a single burst request into a cycle-accurate NONSEQ/SEQ transfer sequence. That sequence includes the address, burst, size and write-data phases, plus per-beat handshakes and completion/error reporting back to the requester.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk`  in  1: single clock, all logic on rising edge.
- `hreset`  in  1: asynchronous, active-high reset.
- `req`  in  2: burst request per requester; must be held until matching `done` bit.
- `req_addr`  in  2*ADDR_W: start address, requester i at bits [i*ADDR_W +: ADDR_W].
- `req_write`  in  2: 1 = write burst.
- `req_burst`  in  2*3: HBURST code.
- `req_size`  in  2*3: HSIZE code, 0..2 only.
- `req_wdata`  in  2*DATA_W: write data for the current beat.
- `hready`  in  1: slave ready.
- `hresp`  in  1: 0 = OKAY, 1 = ERROR.
- `hrdata`  in  DATA_W: read data.
- `m_htrans`  out  2: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- `m_haddr`  out  ADDR_W.
- `m_hwrite`, `m_hburst`, `m_hsize`  out  1/3/3.
- `m_hwdata`  out  DATA_W.
- `m_enable`  out  1: high whenever state ≠ IDLE.
- `grant`  out  2: one-hot owner, 0 in IDLE.
- `beat_ack`  out  2: one-cycle pulse when an address beat of the owner is accepted.
- `rd_valid`  out  1, `rd_data`  out  DATA_W: read beat completed.
- `done`  out  2: one-cycle completion pulse to the owner.
- `err`  out  1: qualifies `done`; 1 = burst aborted by ERROR.

## Operation
- States:
  - IDLE: `m_htrans` = IDLE. If any `req` is set, arbitrate, latch the owner's addr/write/burst/size, set `grant`, go to BURST with beat = 0.
  - BURST: drive NONSEQ for beat 0 and SEQ for later beats. When `hready` = 1: `beat_ack`, beat++, address advances. After the last beat is accepted, go to DRAIN.
  - DRAIN: `m_htrans` = IDLE. Wait for `hready` = 1 (final data phase), then pulse `done`, go to IDLE.
  - ERR: `m_htrans` = IDLE. Wait for `hready` = 1, then pulse `done` and `err`, go to IDLE.
- Beat count by `hburst`:
  - SINGLE 000 → 1; INCR 001 → 1.
  - WRAP4 010, INCR4 011 → 4.
  - WRAP8 100, INCR8 101 → 8.
  - WRAP16 110, INCR16 111 → 16.
- Address step: inc = 1 << hsize.
  - INCR: next = addr + inc, modulo 2^ADDR_W, no 1 KB check.
  - WRAP: B = beats*inc; next = (addr & ~(B-1)) | ((addr+inc) & (B-1)).
- Write data: on each accepted write beat, `m_hwdata` <= owner's `req_wdata` (registered, valid during the data phase). The requester presents the next beat's data the cycle after `beat_ack`.
- Reads: in the data phase of a read beat with `hready` = 1 and `hresp` = 0, pulse `rd_valid` for 1 cycle with `rd_data` = `hrdata`.
- ERROR: `hresp` = 1 with `hready` = 0 in BURST or DRAIN causes `m_htrans` = IDLE on the next cycle (remaining beats cancelled) and state ERR.
- Arbitration: round-robin. A `last` pointer is updated on `done`; when both request, the requester ≠ `last` wins. `last` resets to 1, so requester 0 wins first.
- A `req` drop during a burst is ignored; the burst completes.

## Timing
- Reset values: `m_htrans` = 00, all other outputs 0, state IDLE, `last` = 1.
- `req` sampled in IDLE → `grant` and first NONSEQ appear on the next cycle (1-cycle latency).
- An address is held stable while `hready` = 0; `beat_ack` fires only in a cycle with `hready` = 1.
- `done` fires the cycle after the final data phase completes. Minimum gap to the next NONSEQ is 2 cycles (DRAIN → IDLE → BURST).
- Simultaneous `done` and a new `req` on the same cycle: the new request is not arbitrated until IDLE.
- `hreset` asserted mid-burst: outputs clear asynchronously and `m_htrans` = IDLE immediately; no `done` is issued.

## Configuration
- `AHB_ARB_PRIO_EN`:
  - Defined: fixed priority, requester 0 always wins a tie; `last` pointer removed.
  - Undefined: round-robin as above.

## Test plan
- Requester 0, INCR4, addr 0x10, size 2, write data 1..4, `hready` = 1 → haddr 0x10/0x14/0x18/0x1C with htrans NONSEQ,SEQ,SEQ,SEQ; hwdata 1..4; `done[0]` 1 cycle after the last data phase.
- Requester 1, WRAP4 read, addr 0x38, size 2 → haddr 0x38, 0x3C, 0x30, 0x34; four `rd_valid` pulses.
- Both request INCR4 at reset release → requester 0 is served first, then requester 1; with `AHB_ARB_PRIO_EN`, three back-to-back requests from both keep selecting 0.
- `hready` = 0 for 3 cycles on beat 2 of a WRAP8 → address and `m_hwdata` held; exactly 8 `beat_ack` pulses total.
- `hresp` = 1, `hready` = 0 on beat 1 data phase, then `hready` = 1 → htrans IDLE next cycle, `done` with `err` = 1, no further beats.
- `hreset` pulsed during beat 3 of INCR8 → `m_htrans` = 00 and `grant` = 0 immediately; a fresh request after reset restarts at NONSEQ.
